// File: rtl/mul_seq_param_pkg.sv
// Shared arithmetic package for the multi-cycle datapath units.
// Holds the two-state sequencer encoding used by mul_seq_param and a
// conditional two's-complement negate. Divider/sqrt blocks can reuse the
// negate to take operand magnitudes and restore result signs.
package mul_seq_param_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WORK = 1'b1
  } state_e;

  localparam int unsigned MAX_WIDTH = 32;

  typedef logic [2*MAX_WIDTH-1:0] wide_t;

  // Returns -v when neg is set, v otherwise. Callers zero-extend narrower
  // values into wide_t and truncate the result back to their own width.
  // Modulo arithmetic makes that truncation exact.
  function automatic wide_t cond_neg(input wide_t v, input logic neg);
    return neg ? (~v + wide_t'(1)) : v;
  endfunction

endpackage

// File: rtl/mul_seq_param.sv
// mul_seq_param: sequential shift-add multiplier with WIDTH-bit operands
// and a 2*WIDTH-bit registered product.
// Ports:
//   clk_i     clock, rising edge
//   rst_i     asynchronous active-high reset
//   a_bi      multiplicand
//   b_bi      multiplier
//   signed_i  1 = both operands are two's complement, sampled at start
//   start_i   start request, honoured only while idle
//   busy_o    high while iterating
//   done_o    one-cycle pulse after y_bo has been updated
//   y_bo      product, held until the next completion
// Signed operation multiplies magnitudes and negates the product at the end.
// With EARLY_TERM set, iteration stops once the remaining multiplier bits
// are all zero.
module mul_seq_param
  import mul_seq_param_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter bit          EARLY_TERM = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [WIDTH-1:0]   a_bi,
  input  logic [WIDTH-1:0]   b_bi,
  input  logic               signed_i,
  input  logic               start_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] y_bo
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CTR_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_mag_q, a_mag_d;
  logic [WIDTH-1:0] b_sh_q,  b_sh_d;
  logic             neg_q,   neg_d;
  logic [PW-1:0]    acc_q,   acc_d;
  logic [CW-1:0]    ctr_q,   ctr_d;
  logic [PW-1:0]    y_q,     y_d;
  logic             done_q,  done_d;

  logic             accept;
  logic             last_iter;
  logic [WIDTH-1:0] a_mag_w;
  logic [WIDTH-1:0] b_mag_w;
  logic [PW-1:0]    addend;
  logic [PW-1:0]    acc_n;
  logic [PW-1:0]    y_w;

  // State register: every flop of the unit, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      a_mag_q <= '0;
      b_sh_q  <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      ctr_q   <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_mag_q <= a_mag_d;
      b_sh_q  <= b_sh_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      ctr_q   <= ctr_d;
      y_q     <= y_d;
      done_q  <= done_d;
    end
  end

  // Shared datapath: one adder, the shifted multiplicand and the
  // termination test.
  always_comb begin
    accept  = (state_q == IDLE) && start_i;
    // The most-negative operand maps to 2^(WIDTH-1), which still fits unsigned.
    a_mag_w = WIDTH'(cond_neg(wide_t'(a_bi), signed_i & a_bi[WIDTH-1]));
    b_mag_w = WIDTH'(cond_neg(wide_t'(b_bi), signed_i & b_bi[WIDTH-1]));
    addend  = b_sh_q[0] ? (PW'(a_mag_q) << ctr_q) : '0;
    acc_n   = acc_q + addend;
    y_w     = PW'(cond_neg(wide_t'(acc_n), neg_q));
    // b_sh_q >> 1 is the multiplier still to be consumed after this cycle.
    last_iter = (ctr_q == CTR_LAST) ||
                (EARLY_TERM && ((b_sh_q >> 1) == '0));
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i)   state_d = WORK;
      WORK:    if (last_iter) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Register inputs and outputs.
  always_comb begin
    a_mag_d = a_mag_q;
    b_sh_d  = b_sh_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    ctr_d   = ctr_q;
    y_d     = y_q;
    done_d  = 1'b0;

    if (accept) begin
      a_mag_d = a_mag_w;
      b_sh_d  = b_mag_w;
      neg_d   = signed_i & (a_bi[WIDTH-1] ^ b_bi[WIDTH-1]);
      acc_d   = '0;
      ctr_d   = '0;
    end else if (state_q == WORK) begin
      acc_d  = acc_n;
      b_sh_d = b_sh_q >> 1;
      ctr_d  = ctr_q + CW'(1);
      if (last_iter) begin
        y_d    = y_w;
        done_d = 1'b1;
      end
    end

    busy_o = (state_q == WORK);
    done_o = done_q;
    y_bo   = y_q;
  end

endmodule

// File: tb/tb_mul_seq_param.sv
// Bench for mul_seq_param: three instances (8-bit early-terminating,
// 8-bit fixed-latency, 16-bit early-terminating) checked every cycle
// against an arithmetic reference model.
module tb_mul_seq_param;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int unsigned w_of  [NI] = '{8, 8, 16};
  bit          et_of [NI] = '{1'b1, 1'b0, 1'b1};

  logic [31:0] a_s  [NI];
  logic [31:0] b_s  [NI];
  logic        sg_s [NI];
  logic        st_s [NI];
  logic        busy_s [NI];
  logic        done_s [NI];
  logic [63:0] y_s  [NI];

  logic        bz0, bz1, bz2, dn0, dn1, dn2;
  logic [15:0] y0, y1;
  logic [31:0] y2;

  mul_seq_param #(.WIDTH(8), .EARLY_TERM(1'b1)) u_et8 (
    .clk_i(clk), .rst_i(rst), .a_bi(a_s[0][7:0]), .b_bi(b_s[0][7:0]),
    .signed_i(sg_s[0]), .start_i(st_s[0]), .busy_o(bz0), .done_o(dn0), .y_bo(y0));

  mul_seq_param #(.WIDTH(8), .EARLY_TERM(1'b0)) u_fix8 (
    .clk_i(clk), .rst_i(rst), .a_bi(a_s[1][7:0]), .b_bi(b_s[1][7:0]),
    .signed_i(sg_s[1]), .start_i(st_s[1]), .busy_o(bz1), .done_o(dn1), .y_bo(y1));

  mul_seq_param #(.WIDTH(16), .EARLY_TERM(1'b1)) u_et16 (
    .clk_i(clk), .rst_i(rst), .a_bi(a_s[2][15:0]), .b_bi(b_s[2][15:0]),
    .signed_i(sg_s[2]), .start_i(st_s[2]), .busy_o(bz2), .done_o(dn2), .y_bo(y2));

  always_comb begin
    busy_s[0] = bz0; busy_s[1] = bz1; busy_s[2] = bz2;
    done_s[0] = dn0; done_s[1] = dn1; done_s[2] = dn2;
    y_s[0] = 64'(y0); y_s[1] = 64'(y1); y_s[2] = 64'(y2);
  end

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint unsigned ref_prod(int unsigned w, bit s,
                                               longint unsigned a, longint unsigned b);
    longint sa, sb, p;
    longint unsigned mask;
    sa = $signed((s && a[w-1]) ? a - (64'd1 << w) : a);
    sb = $signed((s && b[w-1]) ? b - (64'd1 << w) : b);
    p = sa * sb;
    mask = (w >= 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2*w)) - 64'd1);
    return $unsigned(p) & mask;
  endfunction

  function automatic int ref_lat(int unsigned w, bit et, bit s, longint unsigned b);
    longint unsigned mag;
    int n;
    if (!et) return int'(w);
    mag = (s && b[w-1]) ? ((64'd1 << w) - b) : b;
    n = 1;
    for (int k = 0; k < int'(w); k++) if (mag[k]) n = k + 1;
    return n;
  endfunction

  longint unsigned m_y [NI];
  longint unsigned m_pend [NI];
  int              m_rem [NI];
  bit              m_done [NI];

  // Remaining busy cycles; product published when the count runs out.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NI; i++) begin
        m_y[i] <= 0; m_pend[i] <= 0; m_rem[i] <= 0; m_done[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        if (m_rem[i] > 0) begin
          m_rem[i]  <= m_rem[i] - 1;
          m_done[i] <= (m_rem[i] == 1);
          if (m_rem[i] == 1) m_y[i] <= m_pend[i];
        end else begin
          m_done[i] <= 1'b0;
          if (st_s[i]) begin
            m_rem[i]  <= ref_lat(w_of[i], et_of[i], sg_s[i], 64'(b_s[i]));
            m_pend[i] <= ref_prod(w_of[i], sg_s[i], 64'(a_s[i]), 64'(b_s[i]));
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("busy[%0d]", i), 64'(busy_s[i]), 64'(m_rem[i] > 0));
        chk($sformatf("done[%0d]", i), 64'(done_s[i]), 64'(m_done[i]));
        chk($sformatf("y[%0d]", i), y_s[i], m_y[i]);
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] msk(int i, longint unsigned v);
    return 32'(v & ((64'd1 << w_of[i]) - 64'd1));
  endfunction

  task automatic run_op(input string tag, input int i, input longint unsigned a,
                        input longint unsigned b, input bit s,
                        input longint unsigned exp_y, input int exp_cyc, input bit poke);
    int cyc;
    @(posedge clk); #1;
    a_s[i] = msk(i, a); b_s[i] = msk(i, b); sg_s[i] = s; st_s[i] = 1'b1;
    @(posedge clk); #1;
    st_s[i] = 1'b0;
    a_s[i] = msk(i, {$urandom, $urandom}); b_s[i] = msk(i, {$urandom, $urandom});
    sg_s[i] = 1'($urandom_range(0, 1));
    cyc = 0;
    while (busy_s[i] && cyc < 100) begin
      cyc++;
      st_s[i] = (poke && cyc == 3);
      @(posedge clk); #1;
    end
    st_s[i] = 1'b0;
    chk({tag, "_done"}, 64'(done_s[i]), 64'd1);
    chk({tag, "_cycles"}, 64'(cyc), 64'(exp_cyc));
    chk({tag, "_y"}, y_s[i], exp_y);
  endtask

  function automatic longint unsigned pick(int i);
    case ($urandom_range(0, 7))
      0: return 0;
      1: return 64'd1 << (w_of[i] - 1);
      2: return (64'd1 << w_of[i]) - 1;
      default: return 64'(msk(i, {$urandom, $urandom}));
    endcase
  endfunction

  task automatic rand_op(input int i);
    int cyc;
    @(posedge clk); #1;
    a_s[i] = msk(i, pick(i)); b_s[i] = msk(i, pick(i));
    sg_s[i] = 1'($urandom_range(0, 1)); st_s[i] = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    while (busy_s[i] && cyc < 100) begin
      cyc++;
      st_s[i] = ($urandom_range(0, 3) == 0);
      a_s[i] = msk(i, {$urandom, $urandom}); b_s[i] = msk(i, {$urandom, $urandom});
      @(posedge clk); #1;
    end
    st_s[i] = 1'b0;
    if (cyc >= 100) chk("rand_timeout", 64'(cyc), 64'd0);
  endtask

  initial begin
    int cyc, pulses;
    for (int i = 0; i < NI; i++) begin
      a_s[i] = '0; b_s[i] = '0; sg_s[i] = 1'b0; st_s[i] = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_busy[%0d]", i), 64'(busy_s[i]), 64'd0);
      chk($sformatf("rst_done[%0d]", i), 64'(done_s[i]), 64'd0);
      chk($sformatf("rst_y[%0d]", i), y_s[i], 64'd0);
    end
    @(negedge clk); #1;
    rst = 1'b0;

    run_op("u200x150",  0, 200,   150,   1'b0, 64'h7530,     8,  1'b1);
    run_op("sm3x5",     0, 8'hFD, 8'h05, 1'b1, 64'hFFF1,     3,  1'b0);
    run_op("s80x80",    0, 8'h80, 8'h80, 1'b1, 64'h4000,     8,  1'b0);
    run_op("uFFx2",     0, 8'hFF, 8'h02, 1'b0, 64'h01FE,     2,  1'b0);
    run_op("sFFx2",     0, 8'hFF, 8'h02, 1'b1, 64'hFFFE,     2,  1'b0);
    run_op("et_b0",     0, 8'hFF, 8'h00, 1'b0, 64'h0000,     1,  1'b0);
    run_op("fix_b0",    1, 8'hFF, 8'h00, 1'b0, 64'h0000,     8,  1'b0);
    run_op("fix_u5x7",  1, 8'h05, 8'h07, 1'b0, 64'h0023,     8,  1'b0);
    run_op("w16_max",   2, 16'hFFFF, 16'hFFFF, 1'b0, 64'hFFFE0001, 16, 1'b0);

    // Back-to-back: start held through the done cycle.
    @(posedge clk); #1;
    a_s[0] = 32'd7; b_s[0] = 32'd9; sg_s[0] = 1'b0; st_s[0] = 1'b1;
    @(posedge clk); #1;
    a_s[0] = 32'd3; b_s[0] = 32'd5;
    cyc = 0;
    while (busy_s[0] && cyc < 100) begin cyc++; @(posedge clk); #1; end
    chk("b2b_first_cycles", 64'(cyc), 64'd4);
    chk("b2b_first_done", 64'(done_s[0]), 64'd1);
    chk("b2b_first_y", y_s[0], 64'h3F);
    @(posedge clk); #1;
    st_s[0] = 1'b0;
    chk("b2b_rebusy", 64'(busy_s[0]), 64'd1);
    cyc = 0;
    while (busy_s[0] && cyc < 100) begin cyc++; @(posedge clk); #1; end
    chk("b2b_second_cycles", 64'(cyc), 64'd3);
    chk("b2b_second_y", y_s[0], 64'h0F);

    // Asynchronous reset in the third WORK cycle.
    @(posedge clk); #1;
    a_s[0] = 32'h12; b_s[0] = 32'hFF; sg_s[0] = 1'b0; st_s[0] = 1'b1;
    @(posedge clk); #1;
    st_s[0] = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("pre_rst_busy", 64'(busy_s[0]), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_busy", 64'(busy_s[0]), 64'd0);
    chk("async_rst_done", 64'(done_s[0]), 64'd0);
    chk("async_rst_y", y_s[0], 64'd0);
    @(negedge clk); #1;
    rst = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done_s[0]) pulses++;
    end
    chk("no_done_after_rst", 64'(pulses), 64'd0);

    repeat (150) rand_op($urandom_range(0, NI - 1));

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
